rst_seq: RTL and testbench
==========================

# rst_seq

Reset sequencer that sits directly downstream of the FPGA power-on reset controller. It takes the controller's active-low system reset and releases `NumDomains` subsystem resets in a fixed order: domain 0 first, e.g. interconnect/memories, then peripherals, then the Ibex core. Consecutive releases are separated by a programmable gap, and optionally gated by a per-domain ready acknowledgement. The block also provides a software/debug-requested re-sequence path that does not need a full power-on reset.

## Interface
- `NumDomains`, default 3: number of sequenced reset outputs; legal range 1–8.
- `SyncStages`, default 2: depth of the reset-deassertion synchronizer; minimum 2.
- `ReleaseGap`, default 16: cycles between successive domain releases; minimum 1.
- `AckTimeout`, default 1024: maximum cycles to wait for `dom_ready_i[i]` before proceeding anyway.
- `clk_i` input 1: single clock for the whole block.
- `rst_ni` input 1: asynchronous, active-low reset, driven by the power-on reset controller output.
- `sw_rst_req_i` input 1: synchronous single-cycle pulse; re-asserts all domains and restarts the sequence.
- `dom_ready_i` input `NumDomains`: level; domain i reports that it has finished initialisation.
- `rst_dom_no` output `NumDomains`: active-low reset for each domain.
- `seq_done_o` output 1: high once all domains are released.
- `timeout_o` output 1: sticky flag; set if any acknowledgement timed out.

## Operation
- Reset values while `rst_ni`=0: all `rst_dom_no`=0, `seq_done_o`=0, `timeout_o`=0, FSM in SYNC, index=0, counter=0.
- Assertion of `rst_ni` is asynchronous on every output flop. Deassertion passes through a `SyncStages`-flop synchronizer.
- FSM states and transitions:
  - SYNC: waits for the synchronized reset to go high, then moves to GAP.
  - GAP: counts `ReleaseGap` cycles, then moves to RELEASE.
  - RELEASE: deasserts `rst_dom_no[index]` (one cycle), then moves to WAIT.
  - WAIT: waits for the acknowledgement (see Configuration). If index = `NumDomains`-1, moves to DONE; otherwise increments index and moves to GAP.
  - DONE: `seq_done_o`=1. Stays here until a reset event.
- Domains are only ever released in ascending index order. Once released, a domain stays deasserted until the next reset event.
- `sw_rst_req_i`=1 in any state other than SYNC:
  - next cycle, all `rst_dom_no`=0 and `seq_done_o`=0;
  - index=0, counter cleared, FSM goes to GAP;
  - `timeout_o` is not cleared (only `rst_ni` clears it).
- `sw_rst_req_i` during SYNC is ignored. A request in the same cycle as a GAP/WAIT completion takes priority over the completion.
- Counter width is `$clog2(max(ReleaseGap, AckTimeout)+1)`. The counter saturates and never wraps.
- `rst_ni` low mid-sequence: the block returns to the reset values immediately and asynchronously.

## Timing
- Let edge 0 be the first `clk_i` edge that samples `rst_ni`=1.
  - The synchronized reset goes high at edge `SyncStages`.
  - `rst_dom_no[0]` rises at edge `SyncStages`+`ReleaseGap`+1.
- Without ack: `rst_dom_no[i+1]` rises exactly `ReleaseGap`+2 cycles after `rst_dom_no[i]`.
- With ack: `rst_dom_no[i+1]` rises `ReleaseGap`+1 cycles after the first cycle that samples `dom_ready_i[i]`=1 in WAIT.
- `seq_done_o` rises 2 cycles after the last domain's release condition is met.
- All outputs are driven directly from flops, so they are glitch-free.

## Configuration
- Macro `RST_SEQ_ACK_EN`.
- Defined:
  - WAIT holds until `dom_ready_i[index]`=1, or until `AckTimeout` cycles have elapsed.
  - On timeout, `timeout_o` is set and the sequence proceeds.
  - `dom_ready_i` is sampled through a 2-flop synchronizer.
- Undefined:
  - WAIT lasts exactly one cycle.
  - `dom_ready_i` is unused.
  - `timeout_o` is tied to 0.

## Structure
- `rst_seq_pkg`: FSM state enum (`SYNC`, `GAP`, `RELEASE`, `WAIT`, `DONE`) and a counter-width helper function.
- One sub-module, `rst_sync`: async-assert, sync-deassert synchronizer parameterised by `SyncStages`. It is reused for `rst_ni`; the ready synchronizers use plain 2-flop chains.

## Test plan
- Power-on, no ack, defaults:
  - `rst_ni` rises at edge 0 → domains 0/1/2 rise at edges 19/37/55;
  - `seq_done_o` rises at edge 57.
- `RST_SEQ_ACK_EN`, `dom_ready_i[0]` raised 100 cycles after domain 0 release → domain 1 held low until 17 cycles after ready is sampled; `timeout_o`=0.
- `RST_SEQ_ACK_EN`, `dom_ready_i[1]` never raised, `AckTimeout`=1024 → domain 2 released after the timeout; `timeout_o`=1 and stays 1.
- `sw_rst_req_i` pulse in DONE → all outputs 0 next cycle; sequence replays from GAP with identical spacing; `timeout_o` retained.
- `rst_ni` dropped mid-GAP with domain 1 released → all outputs 0 with no clock edge; full sequence replays after `rst_ni` rises.
- `sw_rst_req_i` in the same cycle as the GAP completion for domain 1 → domain 1 not released; sequence restarts at index 0.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        StSync,
        StGap,
        StRelease,
        StWait,
        StDone
    } rst_seq_state_e;

    // Width needed to hold the larger of the gap and ack-timeout counts.
    function automatic int unsigned cnt_width(input int unsigned gap, input int unsigned timeout);
        int unsigned m;
        m = (gap > timeout) ? gap : timeout;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset synchronizer: asserts asynchronously, deasserts after SyncStages clock edges.
module rst_sync #(
    parameter int unsigned SyncStages = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic rst_no
);

    logic [SyncStages-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], 1'b1};
        end
    end

    assign rst_no = sync_q[SyncStages-1];

endmodule

// File: rtl/rst_seq.sv
// Ordered release of NumDomains subsystem resets with programmable gap and software re-sequence.
// Define RST_SEQ_ACK_EN to gate each release on a synchronized per-domain ready with timeout.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int unsigned NumDomains = 3,
    parameter int unsigned SyncStages = 2,
    parameter int unsigned ReleaseGap = 16,
    parameter int unsigned AckTimeout = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  sw_rst_req_i,
    input  logic [NumDomains-1:0] dom_ready_i,
    output logic [NumDomains-1:0] rst_dom_no,
    output logic                  seq_done_o,
    output logic                  timeout_o
);

    localparam int unsigned CntW = cnt_width(ReleaseGap, AckTimeout);
    localparam int unsigned IdxW = (NumDomains > 1) ? $clog2(NumDomains) : 1;

    localparam logic [CntW-1:0] GapLast = CntW'(ReleaseGap - 1);
    localparam logic [CntW-1:0] CntMax  = '1;
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NumDomains - 1);

    rst_seq_state_e        state_q, state_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [NumDomains-1:0] rst_dom_q, rst_dom_d;
    logic                  done_q, done_d;
    logic                  timeout_q, timeout_d;
    logic                  rst_sync_n;
    logic                  ack_ok;
    logic                  ack_expired;

    rst_sync #(
        .SyncStages(SyncStages)
    ) u_rst_sync (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .rst_no(rst_sync_n)
    );

`ifdef RST_SEQ_ACK_EN
    localparam logic [CntW-1:0] AckLast = CntW'(AckTimeout - 1);

    logic [NumDomains-1:0] ready_meta_q, ready_sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ready_meta_q <= '0;
            ready_sync_q <= '0;
        end else begin
            ready_meta_q <= dom_ready_i;
            ready_sync_q <= ready_meta_q;
        end
    end

    assign ack_ok      = ready_sync_q[idx_q];
    assign ack_expired = (cnt_q == AckLast);
`else
    logic unused_ready;
    assign unused_ready = ^dom_ready_i;
    assign ack_ok       = 1'b1;
    assign ack_expired  = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
        rst_dom_d = rst_dom_q;
        done_d    = (state_q == StDone);
        timeout_d = timeout_q;

        case (state_q)
            StSync: begin
                cnt_d = '0;
                if (rst_sync_n) begin
                    state_d = StGap;
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    state_d = StRelease;
                    cnt_d   = '0;
                end
            end
            StRelease: begin
                rst_dom_d[idx_q] = 1'b1;
                state_d          = StWait;
                cnt_d            = '0;
            end
            StWait: begin
                if (ack_ok || ack_expired) begin
                    cnt_d = '0;
                    if (!ack_ok) begin
                        timeout_d = 1'b1;
                    end
                    if (idx_q == IdxLast) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StGap;
                    end
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StSync;
            end
        endcase

        // A software request overrides any completion taken in the same cycle.
        if (sw_rst_req_i && (state_q != StSync)) begin
            state_d   = StGap;
            idx_d     = '0;
            cnt_d     = '0;
            rst_dom_d = '0;
            done_d    = 1'b0;
            timeout_d = timeout_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StSync;
            idx_q     <= '0;
            cnt_q     <= '0;
            rst_dom_q <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            rst_dom_q <= rst_dom_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    assign rst_dom_no = rst_dom_q;
    assign seq_done_o = done_q;
    assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq: expected release edges are queued as stimulus is applied.
module tb_rst_seq;

    localparam int NumDomains = 3;
    localparam int SelDone    = NumDomains;

    logic                  clk        = 1'b0;
    logic                  rst_ni     = 1'b1;
    logic                  sw_rst_req = 1'b0;
    logic [NumDomains-1:0] dom_ready  = '1;
    logic [NumDomains-1:0] rst_dom_n;
    logic                  seq_done;
    logic                  timeout;

    int total   = 0;
    int bad     = 0;
    int edge_no = 0;
    int r;
    int e0;

    typedef struct {
        string tag;
        int    sel;
        int    at;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    rst_seq u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .sw_rst_req_i(sw_rst_req),
        .dom_ready_i (dom_ready),
        .rst_dom_no  (rst_dom_n),
        .seq_done_o  (seq_done),
        .timeout_o   (timeout)
    );

    task automatic tick();
        @(posedge clk);
        edge_no++;
        #1;
    endtask

    function automatic logic out_bit(input int sel);
        return (sel < NumDomains) ? rst_dom_n[sel] : seq_done;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want)
        else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic expect_rise(input string tag, input int sel, input int at);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.at  = at;
        sb.push_back(e);
    endtask

    // Pop each expectation and find the first edge where that output is seen high.
    task automatic drain();
        exp_t e;
        int   seen;
        while (sb.size() > 0) begin
            e    = sb.pop_front();
            seen = -1;
            while ((edge_no < e.at + 8) && (seen < 0)) begin
                tick();
                if (out_bit(e.sel) === 1'b1) seen = edge_no;
            end
            check(e.tag, seen, e.at);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_dom"}, 32'(rst_dom_n), 32'd0);
        check({tag, "_done"}, 32'(seq_done), 32'd0);
        check({tag, "_to"}, 32'(timeout), 32'd0);
    endtask

    task automatic power_on(input string tag);
        rst_ni = 1'b0;
        #2;
        check_zero(tag);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_ni  = 1'b1;
        edge_no = -1;
    endtask

    task automatic sw_pulse();
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
    endtask

    initial begin
        // Power-on release order and spacing.
        power_on("por");
        expect_rise("por_dom0", 0, 19);
        expect_rise("por_dom1", 1, 37);
        expect_rise("por_dom2", 2, 55);
        expect_rise("por_done", SelDone, 57);
        drain();

        // Software re-sequence from DONE.
        repeat (3) tick();
        sw_pulse();
        r = edge_no;
        check_zero("sw_done");
        expect_rise("sw_dom0", 0, r + 17);
        expect_rise("sw_dom1", 1, r + 35);
        expect_rise("sw_dom2", 2, r + 53);
        expect_rise("sw_done", SelDone, r + 55);
        drain();

        // Drop rst_ni mid-GAP after domain 1 is out of reset.
        sw_pulse();
        r = edge_no;
        expect_rise("mid_dom0", 0, r + 17);
        expect_rise("mid_dom1", 1, r + 35);
        drain();
        repeat (5) tick();
        check("mid_pre_dom", 32'(rst_dom_n), 32'b011);
        rst_ni = 1'b0;
        #2;
        check_zero("mid_async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni  = 1'b1;
        edge_no = -1;
        expect_rise("rep_dom0", 0, 19);
        expect_rise("rep_dom1", 1, 37);
        expect_rise("rep_dom2", 2, 55);
        expect_rise("rep_done", SelDone, 57);
        drain();

        // Request coinciding with the GAP completion for domain 1.
        sw_pulse();
        r = edge_no;
        expect_rise("col_dom0", 0, r + 17);
        drain();
        e0 = edge_no;
        while (edge_no < e0 + 16) tick();
        sw_pulse();
        r = edge_no;
        check("col_clear", 32'(rst_dom_n), 32'd0);
        tick();
        check("col_dom1_held", 32'(rst_dom_n), 32'd0);
        expect_rise("col_re_dom0", 0, r + 17);
        expect_rise("col_re_dom1", 1, r + 35);
        drain();
        check("no_timeout", 32'(timeout), 32'd0);

`ifdef RST_SEQ_ACK_EN
        // Ack gating: domain 0 ready late, domain 1 never ready.
        dom_ready = 3'b100;
        power_on("ack_por");
        expect_rise("ack_dom0", 0, 19);
        drain();
        while (edge_no < 119) tick();
        dom_ready[0] = 1'b1;
        tick();
        check("ack_dom1_held", 32'(rst_dom_n), 32'b001);
        expect_rise("ack_dom1", 1, 139);
        drain();
        check("ack_no_to", 32'(timeout), 32'd0);
        expect_rise("ack_dom2", 2, 1180);
        drain();
        check("ack_to_set", 32'(timeout), 32'd1);
        expect_rise("ack_done", SelDone, 1182);
        drain();
        sw_pulse();
        check("ack_sw_dom", 32'(rst_dom_n), 32'd0);
        check("ack_to_kept", 32'(timeout), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
